// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: receiver-side byte handshake and downstream command handshake.
interface uart_cmd_sequencer_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frame_err;
    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd_rdy, cmd, data, frame_err
    );
    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd_rdy, cmd, data, frame_err
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: assembles opcode/hi/lo UART bytes into one command with inter-byte timeout.
// Define UART_CMD_CHECKSUM_EN to require a fourth checksum byte (frame sum mod 256 == 0xFF).
module uart_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 52080,
    parameter int TO_W        = 16
) (
    input logic                clk,
    input logic                rst_n,
    uart_cmd_sequencer_if.slave bus
);
`ifdef UART_CMD_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, WAIT_CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
`endif
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    state_t          state_q;
    logic [7:0]      op_q, hi_q, cmd_q;
    logic [15:0]     data_q, data_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            cmd_rdy_q, frame_err_q;
    logic            accept, timeout, commit, chk_fail;
    assign accept  = bus.rx_rdy;
    assign timeout = (state_q != IDLE) && (to_q == TO_LAST) && !accept;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] lo_q, chk_sum;
    assign chk_sum  = op_q + hi_q + lo_q + bus.rx_data;
    assign commit   = accept && (state_q == WAIT_CHK) && (chk_sum == 8'hFF);
    assign chk_fail = accept && (state_q == WAIT_CHK) && (chk_sum != 8'hFF);
    assign data_d   = {hi_q, lo_q};
`else
    assign commit   = accept && (state_q == WAIT_LO);
    assign chk_fail = 1'b0;
    assign data_d   = {hi_q, bus.rx_data};
`endif
    // Saturating counter, held at zero while idle and restarted by every byte.
    assign to_d = (state_q == IDLE || accept || timeout) ? '0 :
                  (to_q == '1) ? to_q : to_q + TO_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            hi_q        <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            lo_q        <= '0;
`endif
            to_q        <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            to_q        <= to_d;
            frame_err_q <= timeout || chk_fail;
            cmd_rdy_q   <= commit || (cmd_rdy_q && !bus.clr_cmd_rdy && !(state_q == IDLE && accept));
            if (commit) begin
                cmd_q  <= op_q;
                data_q <= data_d;
            end
            if (timeout || chk_fail) begin
                state_q <= IDLE;
                op_q    <= '0;
                hi_q    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                lo_q    <= '0;
`endif
            end else if (accept) begin
                case (state_q)
                    IDLE: begin
                        op_q    <= bus.rx_data;
                        state_q <= WAIT_HI;
                    end
                    WAIT_HI: begin
                        hi_q    <= bus.rx_data;
                        state_q <= WAIT_LO;
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    WAIT_LO: begin
                        lo_q    <= bus.rx_data;
                        state_q <= WAIT_CHK;
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    // Combinational consume strobe: a registered one would capture the same byte twice.
    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: table-driven frames plus timeout, clear-collision, reset and checksum sequences.
module tb_uart_cmd_sequencer;
    localparam int T = 200;
    typedef struct {
        logic [7:0]  op, hi, lo;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } vec_t;
    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0, err_cnt = 0, exp_err = 0;
    logic [7:0]  m_cmd = '0;
    logic [15:0] m_data = '0;
    logic prev_rdy = 1'b0, prev_err = 1'b0;
    exp_t sb[$];
    vec_t vecs[4];
    uart_cmd_sequencer_if bus();
    uart_cmd_sequencer #(.TIMEOUT_CYC(T), .TO_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input logic clr);
        bus.rx_rdy = 1'b1;
        bus.rx_data = b;
        bus.clr_cmd_rdy = clr;
        @(negedge clk);
        check("clr_rx_rdy_hi", {31'd0, bus.clr_rx_rdy}, 1);
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
    endtask
    task automatic idle(input int n);
        check("clr_rx_rdy_lo", {31'd0, bus.clr_rx_rdy}, 0);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_tail(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic clr);
`ifdef UART_CMD_CHECKSUM_EN
        logic [7:0] chk;
        chk = 8'hFF - op - hi - lo;
        send_byte(lo, 1'b0);
        send_byte(chk, clr);
`else
        send_byte(lo, clr);
`endif
    endtask
    task automatic check_commit(input logic [7:0] c, input logic [15:0] d);
        check("commit_rdy", {31'd0, bus.cmd_rdy}, 1);
        check("commit_cmd", {24'd0, bus.cmd}, {24'd0, c});
        check("commit_data", {16'd0, bus.data}, {16'd0, d});
        m_cmd = c;
        m_data = d;
    endtask
    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                              input logic clr, input logic [7:0] ec, input logic [15:0] ed);
        sb.push_back({ec, ed});
        send_byte(op, 1'b0);
        check("opcode_clears_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("cmd_hold", {24'd0, bus.cmd}, {24'd0, m_cmd});
        check("data_hold", {16'd0, bus.data}, {16'd0, m_data});
        send_byte(hi, 1'b0);
        send_tail(op, hi, lo, clr);
        check_commit(ec, ed);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.frame_err) begin
                err_cnt++;
                check("frame_err_pulse", {31'd0, prev_err}, 0);
            end
            if (bus.cmd_rdy && !prev_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: cmd %0h data %0h with no frame expected", bus.cmd, bus.data);
                end else begin
                    e = sb.pop_front();
                    check("sb_cmd", {24'd0, bus.cmd}, {24'd0, e.c});
                    check("sb_data", {16'd0, bus.data}, {16'd0, e.d});
                end
            end
            prev_rdy = bus.cmd_rdy;
            prev_err = bus.frame_err;
        end
    end
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{op: 8'h05, hi: 8'h12, lo: 8'h34, exp_cmd: 8'h05, exp_data: 16'h1234};
        vecs[1] = '{op: 8'hA0, hi: 8'hBE, lo: 8'hEF, exp_cmd: 8'hA0, exp_data: 16'hBEEF};
        vecs[2] = '{op: 8'h00, hi: 8'h00, lo: 8'h00, exp_cmd: 8'h00, exp_data: 16'h0000};
        vecs[3] = '{op: 8'hFF, hi: 8'h80, lo: 8'h01, exp_cmd: 8'hFF, exp_data: 16'h8001};
        bus.rx_rdy = 1'b0;
        bus.rx_data = '0;
        bus.clr_cmd_rdy = 1'b0;
        #2;
        check("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("rst_cmd", {24'd0, bus.cmd}, 0);
        check("rst_data", {16'd0, bus.data}, 0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            send_frame(vecs[i].op, vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].exp_cmd, vecs[i].exp_data);
        // Gap of exactly T idle cycles aborts the frame.
        send_byte(8'h07, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(T);
        idle(2);
        exp_err++;
        check("timeout_err_cnt", err_cnt, exp_err);
        check("timeout_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("timeout_cmd", {24'd0, bus.cmd}, {24'd0, m_cmd});
        check("timeout_data", {16'd0, bus.data}, {16'd0, m_data});
        send_frame(8'h09, 8'h00, 8'h02, 1'b0, 8'h09, 16'h0002);
        // Gap of T-1 cycles: byte lands on the terminal count and is accepted.
        sb.push_back({8'h07, 16'h0103});
        send_byte(8'h07, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(T - 1);
        send_tail(8'h07, 8'h01, 8'h03, 1'b0);
        check_commit(8'h07, 16'h0103);
        check("no_timeout_err_cnt", err_cnt, exp_err);
        // Commit collides with clr_cmd_rdy: commit wins.
        send_frame(8'h33, 8'h44, 8'h55, 1'b1, 8'h33, 16'h4455);
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b0;
        check("clr_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("clr_cmd_hold", {24'd0, bus.cmd}, 8'h33);
        // Asynchronous reset mid-frame.
        send_frame(8'h5A, 8'h12, 8'h34, 1'b0, 8'h5A, 16'h1234);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("arst_cmd", {24'd0, bus.cmd}, 0);
        check("arst_data", {16'd0, bus.data}, 0);
        check("arst_frame_err", {31'd0, bus.frame_err}, 0);
        m_cmd = '0;
        m_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h01, 8'h00, 8'h10, 1'b0, 8'h01, 16'h0010);
`ifdef UART_CMD_CHECKSUM_EN
        sb.push_back({8'h02, 16'h1020});
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'hCD, 1'b0);
        check_commit(8'h02, 16'h1020);
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'hCC, 1'b0);
        idle(2);
        exp_err++;
        check("chk_err_cnt", err_cnt, exp_err);
        check("chk_rdy", {31'd0, bus.cmd_rdy}, 0);
        check("chk_cmd", {24'd0, bus.cmd}, 8'h02);
        check("chk_data", {16'd0, bus.data}, 16'h1020);
`endif
        idle(3);
        check("sb_empty", sb.size(), 0);
        check("final_err_cnt", err_cnt, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
